// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer for a single FPAA island crosspoint.
// It repeats inject, settle and measure steps until the target count or the pulse budget is reached.
module fg_prog_sequencer #(
   parameter int unsigned NUM_ROWS      = 3,
   parameter int unsigned NUM_COLS      = 6,
   parameter int unsigned ADDR_W        = 4,
   parameter int unsigned MEAS_W        = 12,
   parameter int unsigned MAXP_W        = 8,
   parameter int unsigned PULSE_CYCLES  = 100,
   parameter int unsigned SETTLE_CYCLES = 20
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_op_i,
   input  logic [ADDR_W-1:0]   cmd_row_i,
   input  logic [ADDR_W-1:0]   cmd_col_i,
   input  logic [MEAS_W-1:0]   cmd_target_i,
   input  logic [MAXP_W-1:0]   cmd_max_pulses_i,
   input  logic                abort_i,
   output logic [ADDR_W-1:0]   row_addr_o,
   output logic [ADDR_W-1:0]   col_addr_o,
   output logic [NUM_ROWS-1:0] drain_sel_o,
   output logic                prog_en_o,
   output logic                inj_pulse_o,
   output logic                meas_req_o,
   input  logic                meas_valid_i,
   input  logic [MEAS_W-1:0]   meas_value_i,
   output logic                done_valid_o,
   input  logic                done_ready_i,
   output logic [1:0]          done_status_o,
   output logic [MAXP_W-1:0]   done_pulses_o,
   output logic [MEAS_W-1:0]   done_meas_o
);

   localparam logic [1:0] StatOk       = 2'd0;
   localparam logic [1:0] StatFailMaxp = 2'd1;
   localparam logic [1:0] StatBadAddr  = 2'd2;
   localparam logic [1:0] StatAbort    = 2'd3;

   localparam int unsigned CntMax = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] PulseLast  = CntW'(PULSE_CYCLES - 1);
   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StMeasure,
      StCheck,
      StPulse,
      StSettle,
      StResp
   } state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic                op_q;
   logic [MEAS_W-1:0]   target_q;
   logic [MAXP_W-1:0]   max_q;
   logic [MAXP_W-1:0]   pulses_q;
   logic [MEAS_W-1:0]   meas_q;
   logic [1:0]          status_q;
   logic                cmd_ready_q;
   logic                prog_en_q;
   logic                inj_pulse_q;
   logic                meas_req_q;
   logic                done_valid_q;
   logic [ADDR_W-1:0]   row_addr_q;
   logic [ADDR_W-1:0]   col_addr_q;
   logic [NUM_ROWS-1:0] drain_sel_q;

   logic       accept;
   logic       addr_bad;
   logic       active;
   logic       go_resp;
   logic [1:0] status_d;

   assign accept   = cmd_valid_i && cmd_ready_q;
   assign addr_bad = (32'(cmd_row_i) >= NUM_ROWS) || (32'(cmd_col_i) >= NUM_COLS);
   assign active   = state_q inside {StSetup, StMeasure, StCheck, StPulse, StSettle};

   // Every path into RESP is decided here; abort takes priority over any measurement result.
   always_comb begin
      go_resp  = 1'b0;
      status_d = StatOk;
      if (active && abort_i) begin
         go_resp  = 1'b1;
         status_d = StatAbort;
      end else if (state_q == StIdle && accept && addr_bad) begin
         go_resp  = 1'b1;
         status_d = StatBadAddr;
      end else if (state_q == StCheck) begin
         if (op_q || (meas_q >= target_q)) begin
            go_resp = 1'b1;
         end else if (pulses_q == max_q) begin
            go_resp  = 1'b1;
            status_d = StatFailMaxp;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         op_q         <= 1'b0;
         target_q     <= '0;
         max_q        <= '0;
         pulses_q     <= '0;
         meas_q       <= '0;
         status_q     <= StatOk;
         cmd_ready_q  <= 1'b1;
         prog_en_q    <= 1'b0;
         inj_pulse_q  <= 1'b0;
         meas_req_q   <= 1'b0;
         done_valid_q <= 1'b0;
         row_addr_q   <= '0;
         col_addr_q   <= '0;
         drain_sel_q  <= '0;
      end else if (go_resp) begin
         state_q      <= StResp;
         status_q     <= status_d;
         done_valid_q <= 1'b1;
         cmd_ready_q  <= 1'b0;
         cnt_q        <= '0;
         prog_en_q    <= 1'b0;
         inj_pulse_q  <= 1'b0;
         meas_req_q   <= 1'b0;
         row_addr_q   <= '0;
         col_addr_q   <= '0;
         drain_sel_q  <= '0;
         // A rejected command must not report a previous command's results.
         if (state_q == StIdle) begin
            pulses_q <= '0;
            meas_q   <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  op_q        <= cmd_op_i;
                  target_q    <= cmd_target_i;
                  max_q       <= cmd_max_pulses_i;
                  pulses_q    <= '0;
                  meas_q      <= '0;
                  cnt_q       <= '0;
                  cmd_ready_q <= 1'b0;
                  row_addr_q  <= cmd_row_i;
                  col_addr_q  <= cmd_col_i;
                  drain_sel_q <= NUM_ROWS'(1) << cmd_row_i;
                  prog_en_q   <= 1'b1;
                  state_q     <= StSetup;
               end
            end
            StSetup, StSettle: begin
               if (cnt_q == SettleLast) begin
                  cnt_q      <= '0;
                  meas_req_q <= 1'b1;
                  state_q    <= StMeasure;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StMeasure: begin
               meas_req_q <= 1'b0;
               if (meas_valid_i) begin
                  meas_q  <= meas_value_i;
                  state_q <= StCheck;
               end
            end
            StCheck: begin
               inj_pulse_q <= 1'b1;
               cnt_q       <= '0;
               state_q     <= StPulse;
            end
            StPulse: begin
               if (cnt_q == PulseLast) begin
                  inj_pulse_q <= 1'b0;
                  pulses_q    <= pulses_q + 1'b1;
                  cnt_q       <= '0;
                  state_q     <= StSettle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StResp: begin
               if (done_ready_i) begin
                  done_valid_q <= 1'b0;
                  cmd_ready_q  <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready_o   = cmd_ready_q;
   assign row_addr_o    = row_addr_q;
   assign col_addr_o    = col_addr_q;
   assign drain_sel_o   = drain_sel_q;
   assign prog_en_o     = prog_en_q;
   assign inj_pulse_o   = inj_pulse_q;
   assign meas_req_o    = meas_req_q;
   assign done_valid_o  = done_valid_q;
   assign done_status_o = status_q;
   assign done_pulses_o = pulses_q;
   assign done_meas_o   = meas_q;

   inj_safe_a: assert property (@(posedge clk_i) disable iff (reset_i)
      inj_pulse_q |-> (prog_en_q && (drain_sel_q != '0)));
   drain_onehot_a: assert property (@(posedge clk_i) $onehot0(drain_sel_q));

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer with short pulse/settle times and a one-cycle ADC model.
module tb_fg_prog_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_op = 1'b0;
   logic [3:0]  cmd_row = '0;
   logic [3:0]  cmd_col = '0;
   logic [11:0] cmd_target = '0;
   logic [7:0]  cmd_max_pulses = '0;
   logic        abort = 1'b0;
   logic [3:0]  row_addr;
   logic [3:0]  col_addr;
   logic [2:0]  drain_sel;
   logic        prog_en;
   logic        inj_pulse;
   logic        meas_req;
   logic        meas_valid = 1'b0;
   logic [11:0] meas_value = '0;
   logic        done_valid;
   logic        done_ready = 1'b0;
   logic [1:0]  done_status;
   logic [7:0]  done_pulses;
   logic [11:0] done_meas;

   int n_cmp = 0;
   int n_fail = 0;

   logic [11:0] adc_vals[4];
   int          adc_n = 1;
   int          adc_idx = 0;
   logic        adc_pending = 1'b0;

   int          run_len;
   int          runs[$];
   bit          pe_seen;
   int          drain_bad;
   int          inj_bad;
   int          req_cnt;
   logic [2:0]  exp_drain;

   fg_prog_sequencer #(
      .NUM_ROWS     (3),
      .NUM_COLS     (6),
      .ADDR_W       (4),
      .MEAS_W       (12),
      .MAXP_W       (8),
      .PULSE_CYCLES (4),
      .SETTLE_CYCLES(2)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .cmd_valid_i     (cmd_valid),
      .cmd_ready_o     (cmd_ready),
      .cmd_op_i        (cmd_op),
      .cmd_row_i       (cmd_row),
      .cmd_col_i       (cmd_col),
      .cmd_target_i    (cmd_target),
      .cmd_max_pulses_i(cmd_max_pulses),
      .abort_i         (abort),
      .row_addr_o      (row_addr),
      .col_addr_o      (col_addr),
      .drain_sel_o     (drain_sel),
      .prog_en_o       (prog_en),
      .inj_pulse_o     (inj_pulse),
      .meas_req_o      (meas_req),
      .meas_valid_i    (meas_valid),
      .meas_value_i    (meas_value),
      .done_valid_o    (done_valid),
      .done_ready_i    (done_ready),
      .done_status_o   (done_status),
      .done_pulses_o   (done_pulses),
      .done_meas_o     (done_meas)
   );

   always #5 clk = ~clk;

   // ADC: answers one cycle after each meas_req, repeating its last table entry.
   always begin
      @(posedge clk);
      #1;
      meas_valid = 1'b0;
      if (adc_pending) begin
         meas_valid  = 1'b1;
         meas_value  = adc_vals[(adc_idx < adc_n) ? adc_idx : adc_n - 1];
         adc_idx++;
         adc_pending = 1'b0;
      end
      if (meas_req && !reset) adc_pending = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #2;
      if (inj_pulse) run_len++;
      else if (run_len != 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
      if (prog_en) pe_seen = 1'b1;
      if (prog_en && drain_sel !== exp_drain) drain_bad++;
      if (inj_pulse && !(prog_en && drain_sel != 3'b000)) inj_bad++;
      if (meas_req) req_cnt++;
   endtask

   task automatic clear_mon(input logic [2:0] drain);
      run_len   = 0;
      runs.delete();
      pe_seen   = 1'b0;
      drain_bad = 0;
      inj_bad   = 0;
      req_cnt   = 0;
      exp_drain = drain;
   endtask

   task automatic load_adc(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                           input int n);
      adc_vals[0] = a;
      adc_vals[1] = b;
      adc_vals[2] = c;
      adc_vals[3] = c;
      adc_n       = n;
      adc_idx     = 0;
   endtask

   task automatic send_cmd(input logic op, input logic [3:0] row, input logic [3:0] col,
                           input logic [11:0] tgt, input logic [7:0] maxp);
      int n;
      cmd_op         = op;
      cmd_row        = row;
      cmd_col        = col;
      cmd_target     = tgt;
      cmd_max_pulses = maxp;
      cmd_valid      = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         step();
         n++;
      end
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles, output bit seen);
      cycles = 0;
      while (!done_valid && cycles < budget) begin
         step();
         cycles++;
      end
      seen = done_valid;
   endtask

   task automatic ack_resp();
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
      n_cmp++;
      if ({row_addr, col_addr, drain_sel, prog_en, inj_pulse, meas_req, done_valid, done_status,
           done_pulses, done_meas} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got prog_en=%0b done_valid=%0b drain=%b exp all zero",
                  prog_en, done_valid, drain_sel);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_program_ok();
      int cyc; bit seen;
      clear_mon(3'b010);
      load_adc(12'd40, 12'd70, 12'd100, 3);
      send_cmd(1'b0, 4'd1, 4'd5, 12'd100, 8'd8);
      n_cmp++;
      if ({prog_en, row_addr, col_addr, drain_sel} !== {1'b1, 4'd1, 4'd5, 3'b010}) begin
         n_fail++;
         $display("FAIL prog_ok_setup got pe=%0b row=%0d col=%0d drain=%b exp 1/1/5/010",
                  prog_en, row_addr, col_addr, drain_sel);
      end
      wait_done(200, cyc, seen);
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL prog_ok_timeout got no done_valid exp done"); end
      n_cmp++; if (cyc != 23) begin n_fail++; $display("FAIL prog_ok_latency got=%0d exp=23", cyc); end
      n_cmp++; if (done_status !== 2'd0) begin n_fail++; $display("FAIL prog_ok_status got=%0d exp=0", done_status); end
      n_cmp++; if (done_pulses !== 8'd2) begin n_fail++; $display("FAIL prog_ok_pulses got=%0d exp=2", done_pulses); end
      n_cmp++; if (done_meas !== 12'd100) begin n_fail++; $display("FAIL prog_ok_meas got=%0d exp=100", done_meas); end
      n_cmp++; if (runs.size() != 2) begin n_fail++; $display("FAIL prog_ok_nruns got=%0d exp=2", runs.size()); end
      n_cmp++;
      if (runs.size() == 2 && (runs[0] != 4 || runs[1] != 4)) begin
         n_fail++;
         $display("FAIL prog_ok_runlen got=%0d,%0d exp=4,4", runs[0], runs[1]);
      end
      n_cmp++; if (drain_bad != 0) begin n_fail++; $display("FAIL prog_ok_drain got=%0d bad cycles exp=0", drain_bad); end
      n_cmp++; if (inj_bad != 0) begin n_fail++; $display("FAIL prog_ok_injsafe got=%0d exp=0", inj_bad); end
      n_cmp++;
      if ({prog_en, row_addr, col_addr, drain_sel} !== '0) begin
         n_fail++;
         $display("FAIL prog_ok_resp_idle_outs got pe=%0b row=%0d drain=%b exp 0", prog_en, row_addr, drain_sel);
      end
      ack_resp();
      n_cmp++;
      if ({cmd_ready, done_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL prog_ok_ack got ready=%0b valid=%0b exp 1/0", cmd_ready, done_valid);
      end
   endtask

   task automatic test_fail_maxp();
      int cyc; bit seen;
      clear_mon(3'b001);
      load_adc(12'd10, 12'd10, 12'd10, 1);
      send_cmd(1'b0, 4'd0, 4'd0, 12'd500, 8'd3);
      wait_done(200, cyc, seen);
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL maxp_timeout got no done_valid exp done"); end
      n_cmp++; if (done_status !== 2'd1) begin n_fail++; $display("FAIL maxp_status got=%0d exp=1", done_status); end
      n_cmp++; if (done_pulses !== 8'd3) begin n_fail++; $display("FAIL maxp_pulses got=%0d exp=3", done_pulses); end
      n_cmp++; if (done_meas !== 12'd10) begin n_fail++; $display("FAIL maxp_meas got=%0d exp=10", done_meas); end
      n_cmp++; if (req_cnt != 4) begin n_fail++; $display("FAIL maxp_meas_reqs got=%0d exp=4", req_cnt); end
      n_cmp++; if (drain_bad != 0) begin n_fail++; $display("FAIL maxp_drain got=%0d exp=0", drain_bad); end
      ack_resp();
   endtask

   task automatic test_bad_addr();
      int cyc; bit seen;
      clear_mon(3'b000);
      send_cmd(1'b0, 4'd3, 4'd0, 12'd100, 8'd4);
      wait_done(4, cyc, seen);
      n_cmp++; if (!seen || cyc != 0) begin n_fail++; $display("FAIL bad_row_latency got=%0d seen=%0b exp=0/1", cyc, seen); end
      n_cmp++; if (done_status !== 2'd2) begin n_fail++; $display("FAIL bad_row_status got=%0d exp=2", done_status); end
      n_cmp++;
      if ({done_pulses, done_meas} !== '0) begin
         n_fail++;
         $display("FAIL bad_row_counts got pulses=%0d meas=%0d exp 0/0", done_pulses, done_meas);
      end
      ack_resp();
      send_cmd(1'b1, 4'd0, 4'd6, 12'd100, 8'd4);
      wait_done(4, cyc, seen);
      n_cmp++; if (done_status !== 2'd2) begin n_fail++; $display("FAIL bad_col_status got=%0d exp=2", done_status); end
      n_cmp++; if (pe_seen) begin n_fail++; $display("FAIL bad_addr_prog_en got=1 exp never"); end
      ack_resp();
   endtask

   task automatic test_read();
      int cyc; bit seen;
      clear_mon(3'b100);
      load_adc(12'h7FF, 12'h7FF, 12'h7FF, 1);
      send_cmd(1'b1, 4'd2, 4'd4, 12'hFFF, 8'd5);
      wait_done(50, cyc, seen);
      n_cmp++; if (!seen || cyc != 5) begin n_fail++; $display("FAIL read_latency got=%0d seen=%0b exp=5/1", cyc, seen); end
      n_cmp++; if (done_status !== 2'd0) begin n_fail++; $display("FAIL read_status got=%0d exp=0", done_status); end
      n_cmp++; if (done_meas !== 12'h7FF) begin n_fail++; $display("FAIL read_meas got=%0h exp=7ff", done_meas); end
      n_cmp++; if (done_pulses !== 8'd0) begin n_fail++; $display("FAIL read_pulses got=%0d exp=0", done_pulses); end
      n_cmp++;
      if (runs.size() != 0 || run_len != 0) begin
         n_fail++;
         $display("FAIL read_inj got runs=%0d exp=0", runs.size());
      end
      n_cmp++; if (drain_bad != 0) begin n_fail++; $display("FAIL read_drain got=%0d exp=0", drain_bad); end
      ack_resp();
   endtask

   task automatic test_zero_budget();
      int cyc; bit seen;
      clear_mon(3'b010);
      load_adc(12'd10, 12'd10, 12'd10, 1);
      send_cmd(1'b0, 4'd1, 4'd2, 12'd500, 8'd0);
      wait_done(50, cyc, seen);
      n_cmp++;
      if ({done_valid, done_status, done_pulses, done_meas} !== {1'b1, 2'd1, 8'd0, 12'd10}) begin
         n_fail++;
         $display("FAIL zero_fail got v=%0b st=%0d p=%0d m=%0d exp 1/1/0/10",
                  done_valid, done_status, done_pulses, done_meas);
      end
      n_cmp++; if (runs.size() != 0 || req_cnt != 1) begin n_fail++; $display("FAIL zero_fail_activity got runs=%0d reqs=%0d exp 0/1", runs.size(), req_cnt); end
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if ({done_valid, done_status, done_pulses, done_meas, prog_en, inj_pulse, drain_sel}
             !== {1'b1, 2'd1, 8'd0, 12'd10, 1'b0, 1'b0, 3'b000}) begin
            n_fail++;
            $display("FAIL resp_hold_c%0d got v=%0b st=%0d p=%0d m=%0d pe=%0b exp 1/1/0/10/0",
                     i, done_valid, done_status, done_pulses, done_meas, prog_en);
         end
      end
      ack_resp();
      load_adc(12'd10, 12'd10, 12'd10, 1);
      send_cmd(1'b0, 4'd1, 4'd2, 12'd5, 8'd0);
      wait_done(50, cyc, seen);
      n_cmp++;
      if ({done_valid, done_status, done_pulses, done_meas} !== {1'b1, 2'd0, 8'd0, 12'd10}) begin
         n_fail++;
         $display("FAIL zero_ok got v=%0b st=%0d p=%0d m=%0d exp 1/0/0/10",
                  done_valid, done_status, done_pulses, done_meas);
      end
      ack_resp();
   endtask

   task automatic test_abort_pulse();
      int n;
      clear_mon(3'b010);
      load_adc(12'd33, 12'd33, 12'd33, 1);
      send_cmd(1'b0, 4'd1, 4'd0, 12'hFFF, 8'd5);
      n = 0;
      while (!inj_pulse && n < 50) begin step(); n++; end
      n_cmp++; if (!inj_pulse) begin n_fail++; $display("FAIL abort_pulse_start got no pulse exp pulse"); end
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_cmp++; if (inj_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_inj got=%0b exp=0", inj_pulse); end
      n_cmp++;
      if ({done_valid, done_status, done_pulses, done_meas} !== {1'b1, 2'd3, 8'd0, 12'd33}) begin
         n_fail++;
         $display("FAIL abort_pulse_resp got v=%0b st=%0d p=%0d m=%0d exp 1/3/0/33",
                  done_valid, done_status, done_pulses, done_meas);
      end
      n_cmp++; if (runs.size() != 1 || runs[0] != 2) begin n_fail++; $display("FAIL abort_pulse_len got n=%0d exp one run of 2", runs.size()); end
      ack_resp();
   endtask

   task automatic test_abort_meas();
      int n;
      clear_mon(3'b001);
      load_adc(12'd55, 12'd55, 12'd55, 1);
      send_cmd(1'b0, 4'd0, 4'd1, 12'hFFF, 8'd5);
      n = 0;
      while (!meas_valid && n < 50) begin step(); n++; end
      n_cmp++; if (!meas_valid) begin n_fail++; $display("FAIL abort_meas_wait got no meas_valid exp valid"); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_cmp++;
      if ({done_valid, done_status, done_pulses, done_meas} !== {1'b1, 2'd3, 8'd0, 12'd0}) begin
         n_fail++;
         $display("FAIL abort_meas_resp got v=%0b st=%0d p=%0d m=%0d exp 1/3/0/0",
                  done_valid, done_status, done_pulses, done_meas);
      end
      ack_resp();
   endtask

   task automatic test_abort_idle();
      abort = 1'b1;
      repeat (3) step();
      abort = 1'b0;
      n_cmp++;
      if ({cmd_ready, done_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL abort_idle got ready=%0b valid=%0b exp 1/0", cmd_ready, done_valid);
      end
   endtask

   task automatic test_reset_mid();
      int n; int seen_done;
      clear_mon(3'b100);
      load_adc(12'd1, 12'd1, 12'd1, 1);
      send_cmd(1'b0, 4'd2, 4'd3, 12'hFFF, 8'd5);
      n = 0;
      while (!inj_pulse && n < 50) begin step(); n++; end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%0b exp=1", cmd_ready); end
      n_cmp++;
      if ({row_addr, col_addr, drain_sel, prog_en, inj_pulse, meas_req, done_valid, done_status,
           done_pulses, done_meas} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs got pe=%0b inj=%0b drain=%b v=%0b exp all zero",
                  prog_en, inj_pulse, drain_sel, done_valid);
      end
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (done_valid) seen_done++;
      end
      n_cmp++; if (seen_done != 0) begin n_fail++; $display("FAIL rst_mid_no_resp got=%0d exp=0", seen_done); end
   endtask

   initial begin
      test_reset();
      test_program_ok();
      test_fail_maxp();
      test_bad_addr();
      test_read();
      test_zero_budget();
      test_abort_pulse();
      test_abort_meas();
      test_abort_idle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
